// File: rtl/clk_freq_gate_ctrl_pkg.sv
// Shared types and defaults for the clock-frequency gate-window controller.
// The FSM state encoding and the parameter defaults live here.
package clk_freq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int unsigned CntWidthDefault = 32;
  localparam int unsigned TimeoutDefault  = 32'h0FFF_FFFF;

endpackage

// File: rtl/clk_freq_gate_ctrl_if.sv
// Control and result signals between the tick source, the controller and the register block.
// The controller uses the slave modport. Its driver uses the master modport.
interface clk_freq_gate_ctrl_if
  import clk_freq_pkg::*;
#(
  parameter int unsigned C_CNT_WIDTH = CntWidthDefault
);

  logic                   enable;
  logic                   ref_tick;
  logic [C_CNT_WIDTH-1:0] freq_count;
  logic                   freq_valid;
  logic [7:0]             meas_seq;
  logic                   timeout;
  logic                   busy;

  modport master (
    output enable, ref_tick,
    input  freq_count, freq_valid, meas_seq, timeout, busy
  );

  modport slave (
    input  enable, ref_tick,
    output freq_count, freq_valid, meas_seq, timeout, busy
  );

endinterface

// File: rtl/clk_freq_gate_ctrl_tick_detect.sv
// Rising-edge detector for the already-synchronised reference tick.
// The history register resets high, so a tick that is held high through reset does not produce an edge.
module clk_freq_tick_detect (
  input  logic user_clk,
  input  logic user_rst_n,
  input  logic ref_tick_i,
  output logic tick_edge_o
);

  logic tick_q;

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) tick_q <= 1'b1;
    else             tick_q <= ref_tick_i;
  end

  assign tick_edge_o = ref_tick_i & ~tick_q;

endmodule

// File: rtl/clk_freq_gate_ctrl.sv
// Counts user_clk cycles between rising edges of the reference tick.
// Publishes the period, a sequence number and timeout status for the register block.
module clk_freq_gate_ctrl
  import clk_freq_pkg::*;
#(
  parameter int unsigned C_CNT_WIDTH = CntWidthDefault,
  parameter int unsigned C_TIMEOUT   = TimeoutDefault
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  clk_freq_gate_ctrl_if.slave  bus
);

  localparam logic [C_CNT_WIDTH-1:0] TimeoutLast = C_CNT_WIDTH'(C_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_CNT_WIDTH-1:0] freq_count_q, freq_count_d;
  logic                   freq_valid_q, freq_valid_d;
  logic [7:0]             meas_seq_q, meas_seq_d;
  logic                   timeout_q, timeout_d;
  logic                   tick_edge;
  logic                   cnt_expired;

  clk_freq_tick_detect u_tick_detect (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .ref_tick_i  (bus.ref_tick),
    .tick_edge_o (tick_edge)
  );

  assign cnt_expired = (cnt_q == TimeoutLast);

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Disabling beats everything; a tick edge beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (tick_edge) state_d = COUNT;
        COUNT:   if (!tick_edge && cnt_expired) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d        = '0;
    freq_count_d = freq_count_q;
    freq_valid_d = 1'b0;
    meas_seq_d   = meas_seq_q;
    timeout_d    = timeout_q;
    if (bus.enable && (state_q == ARM || state_q == COUNT)) begin
      if (tick_edge) begin
        if (state_q == COUNT) begin
          freq_count_d = cnt_q + 1'b1;
          freq_valid_d = 1'b1;
          meas_seq_d   = meas_seq_q + 8'd1;
          timeout_d    = 1'b0;
        end
      end else if (cnt_expired) begin
        freq_count_d = '0;
        timeout_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      cnt_q        <= '0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
      meas_seq_q   <= 8'd0;
      timeout_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      freq_count_q <= freq_count_d;
      freq_valid_q <= freq_valid_d;
      meas_seq_q   <= meas_seq_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.freq_count = freq_count_q;
  assign bus.freq_valid = freq_valid_q;
  assign bus.meas_seq   = meas_seq_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = (state_q == ARM) || (state_q == COUNT);

endmodule

// File: tb/tb_clk_freq_gate_ctrl.sv
// Directed bench for clk_freq_gate_ctrl.
// It covers period measurement, timeout, enable priority, reset recovery and the held-high tick.
module tb_clk_freq_gate_ctrl;

  localparam int unsigned CntWidth = 32;
  localparam int unsigned Timeout  = 1200;

  logic clk;
  logic rstN;
  int   compared;
  int   mismatched;

  clk_freq_gate_ctrl_if #(.C_CNT_WIDTH(CntWidth)) bus ();

  clk_freq_gate_ctrl #(
    .C_CNT_WIDTH (CntWidth),
    .C_TIMEOUT   (Timeout)
  ) dut (
    .user_clk   (clk),
    .user_rst_n (rstN),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advanceCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_count"},   bus.freq_count, 32'd0);
    checkOutput({tag, "_valid"},   32'(bus.freq_valid), 32'd0);
    checkOutput({tag, "_seq"},     32'(bus.meas_seq), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    checkOutput({tag, "_busy"},    32'(bus.busy), 32'd0);
  endtask

  // Single tick edge that is expected to produce no measurement.
  task automatic armTick(input string tag);
    bus.ref_tick = 1'b1;
    advanceCycle();
    bus.ref_tick = 1'b0;
    checkOutput({tag, "_novalid"}, 32'(bus.freq_valid), 32'd0);
  endtask

  // This tick edge lands exactly n cycles after the previous one and must yield a measurement of n.
  task automatic applyStimulus(input string tag, input int n, input int expSeq);
    bus.ref_tick = 1'b0;
    advanceCycle();
    checkOutput({tag, "_pulse_width"}, 32'(bus.freq_valid), 32'd0);
    repeat (n - 2) advanceCycle();
    bus.ref_tick = 1'b1;
    advanceCycle();
    bus.ref_tick = 1'b0;
    checkOutput({tag, "_valid"},   32'(bus.freq_valid), 32'd1);
    checkOutput({tag, "_count"},   bus.freq_count, 32'(n));
    checkOutput({tag, "_seq"},     32'(bus.meas_seq), 32'(expSeq));
    checkOutput({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rstN         = 1'b0;
    bus.enable   = 1'b0;
    bus.ref_tick = 1'b0;
    repeat (3) advanceCycle();
    checkAllZero("reset");
    rstN = 1'b1;

    bus.enable = 1'b1;
    advanceCycle();
    checkOutput("busy_rise", 32'(bus.busy), 32'd1);
    armTick("first_edge");
    applyStimulus("p200_a", 200, 1);
    applyStimulus("p200_b", 200, 2);
    applyStimulus("p200_c", 200, 3);
    applyStimulus("p2",     2,   4);
    applyStimulus("p3",     3,   5);
    applyStimulus("p1000",  1000, 6);
    // A period equal to the timeout: the edge and the timeout coincide, and the edge must win.
    applyStimulus("p_timeout_eq", int'(Timeout), 7);

    repeat (Timeout - 1) advanceCycle();
    checkOutput("count_to_pre", 32'(bus.timeout), 32'd0);
    advanceCycle();
    checkOutput("count_to_flag",  32'(bus.timeout), 32'd1);
    checkOutput("count_to_count", bus.freq_count, 32'd0);
    checkOutput("count_to_valid", 32'(bus.freq_valid), 32'd0);
    checkOutput("count_to_seq",   32'(bus.meas_seq), 32'd7);
    checkOutput("count_to_busy",  32'(bus.busy), 32'd1);
    armTick("after_to_arm");
    checkOutput("after_to_sticky", 32'(bus.timeout), 32'd1);
    applyStimulus("p20_clear", 20, 8);

    repeat (19) advanceCycle();
    bus.ref_tick = 1'b1;
    bus.enable   = 1'b0;
    advanceCycle();
    bus.ref_tick = 1'b0;
    checkOutput("dis_edge_valid", 32'(bus.freq_valid), 32'd0);
    checkOutput("dis_edge_busy",  32'(bus.busy), 32'd0);
    checkOutput("dis_edge_count", bus.freq_count, 32'd20);
    checkOutput("dis_edge_seq",   32'(bus.meas_seq), 32'd8);

    bus.enable = 1'b1;
    advanceCycle();
    checkOutput("reen_busy", 32'(bus.busy), 32'd1);
    armTick("reen_discard");
    applyStimulus("p30", 30, 9);

    bus.enable = 1'b0;
    advanceCycle();
    bus.enable = 1'b1;
    advanceCycle();
    repeat (Timeout - 1) advanceCycle();
    checkOutput("arm_to_pre", 32'(bus.timeout), 32'd0);
    advanceCycle();
    checkOutput("arm_to_flag",  32'(bus.timeout), 32'd1);
    checkOutput("arm_to_count", bus.freq_count, 32'd0);

    rstN         = 1'b0;
    bus.enable   = 1'b0;
    bus.ref_tick = 1'b1;
    repeat (2) advanceCycle();
    checkAllZero("reset_high_tick");
    rstN       = 1'b1;
    bus.enable = 1'b1;
    repeat (5) advanceCycle();
    checkOutput("held_high_busy", 32'(bus.busy), 32'd1);
    bus.ref_tick = 1'b0;
    advanceCycle();
    armTick("held_high_first_real_edge");
    applyStimulus("p40", 40, 1);
    for (int i = 2; i <= 7; i++) applyStimulus("p5", 5, i);

    repeat (3) advanceCycle();
    rstN = 1'b0;
    advanceCycle();
    checkAllZero("reset_mid_count");
    rstN = 1'b1;
    advanceCycle();
    checkOutput("post_reset_busy", 32'(bus.busy), 32'd1);
    armTick("post_reset_arm");
    applyStimulus("p10", 10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
